// File: rtl/twowayhandshake_replayer_if.sv
// Replay channel bundle: replay-buffer packets in, CL valid/ready channel out,
// and completion reports back to the replay controller.
interface twowayhandshake_replayer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic                  replay_en;
  logic                  rep_valid;
  logic                  rep_ready;
  logic [DATA_WIDTH-1:0] rep_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  repe_valid;
  logic                  repe_ready;
  logic [CNT_WIDTH-1:0]  pend_cnt;

  // Replayer side.
  modport master (
    input  replay_en, rep_valid, rep_data, out_ready, repe_ready,
    output rep_ready, out_valid, out_data, repe_valid, pend_cnt
  );

  // Controller / CL side.
  modport slave (
    output replay_en, rep_valid, rep_data, out_ready, repe_ready,
    input  rep_ready, out_valid, out_data, repe_valid, pend_cnt
  );
endinterface

// File: rtl/twowayhandshake_replayer.sv
// Re-drives recorded transactions into the CL through a one-entry output
// register and reports every CL-side completion back to the replay controller.
module twowayhandshake_replayer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  twowayhandshake_replayer_if.master   bus,
  output logic                         dbg_full
);

  // All three channels are valid/ready: a transfer happens on the rising edge
  // where valid and ready are both high; a raised valid holds its payload
  // until that transfer, and valid never waits combinationally on ready.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

  state_t               state;
  logic                 rep_hs;
  logic                 out_hs;
  logic                 repe_hs;
  logic [CNT_WIDTH:0]   occupancy;

  // Accepted packets still owed a completion slot: counted ones plus the held one.
  assign occupancy     = {1'b0, bus.pend_cnt} + {{CNT_WIDTH{1'b0}}, bus.out_valid};
  assign bus.rep_ready = rstn && bus.replay_en && (!bus.out_valid || bus.out_ready)
                         && (occupancy < CNT_MAX);

  assign rep_hs        = bus.rep_valid && bus.rep_ready;
  assign out_hs        = bus.out_valid && bus.out_ready;
  assign repe_hs       = bus.repe_valid && bus.repe_ready;

  assign bus.out_valid  = (state == FULL);
  assign bus.repe_valid = (bus.pend_cnt != '0);
  assign dbg_full       = (state == FULL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= EMPTY;
      bus.out_data <= '0;
      bus.pend_cnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (rep_hs) begin
            state        <= FULL;
            bus.out_data <= bus.rep_data;
          end
        end
        FULL: begin
          // A fresh packet replaces the one leaving, so no bubble is inserted.
          if (rep_hs) begin
            bus.out_data <= bus.rep_data;
          end else if (out_hs) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase

      case ({out_hs, repe_hs})
        2'b10:   bus.pend_cnt <= bus.pend_cnt + 1'b1;
        2'b01:   bus.pend_cnt <= bus.pend_cnt - 1'b1;
        default: bus.pend_cnt <= bus.pend_cnt;
      endcase
    end
  end

`ifdef FORMAL
  logic [31:0] f_rep_cnt;
  logic [31:0] f_out_cnt;
  logic [31:0] f_repe_cnt;
  logic        f_past_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_rep_cnt    <= '0;
      f_out_cnt    <= '0;
      f_repe_cnt   <= '0;
      f_past_valid <= 1'b0;
    end else begin
      f_rep_cnt    <= f_rep_cnt + {31'd0, rep_hs};
      f_out_cnt    <= f_out_cnt + {31'd0, out_hs};
      f_repe_cnt   <= f_repe_cnt + {31'd0, repe_hs};
      f_past_valid <= 1'b1;
    end
  end

  a_out_hold: assert property (@(posedge clk) disable iff (!rstn)
    bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data));
  a_repe_hold: assert property (@(posedge clk) disable iff (!rstn)
    bus.repe_valid && !bus.repe_ready |=> bus.repe_valid);
  a_inv_rep: assert property (@(posedge clk) disable iff (!rstn)
    f_rep_cnt == f_out_cnt + {31'd0, bus.out_valid});
  a_inv_out: assert property (@(posedge clk) disable iff (!rstn)
    f_out_cnt == f_repe_cnt + {{(32-CNT_WIDTH){1'b0}}, bus.pend_cnt});
  a_cnt_max: assert property (@(posedge clk) disable iff (!rstn)
    {1'b0, bus.pend_cnt} <= CNT_MAX);
  a_reset_empty: assert property (@(posedge clk) disable iff (!rstn)
    !f_past_valid |-> !bus.out_valid);
`endif

endmodule

// File: tb/tb_twowayhandshake_replayer.sv
// Directed bench for twowayhandshake_replayer: a queue/counter model of the
// replay channel checked every cycle, plus hand-computed literal checkpoints.
module tb_twowayhandshake_replayer;

  localparam int DW      = 32;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic dbg_full;
  always #5 clk = ~clk;

  twowayhandshake_replayer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  twowayhandshake_replayer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus.master),
    .dbg_full (dbg_full)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // exp_q holds the packet currently owed to the CL; m_pend counts CL
  // completions not yet taken by the controller.
  logic [DW-1:0] exp_q[$];
  int            m_pend = 0;

  function automatic bit m_rep_ready();
    return rstn && bus.replay_en && (exp_q.size() == 0 || bus.out_ready)
           && (m_pend + exp_q.size() < CNT_MAX);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      m_pend = 0;
    end else begin
      bit acc, deliver, report;
      acc     = bus.rep_valid && m_rep_ready();
      deliver = (exp_q.size() != 0) && bus.out_ready;
      report  = (m_pend != 0) && bus.repe_ready;
      if (deliver) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(bus.rep_data);
      m_pend = m_pend + int'(deliver) - int'(report);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("rep_ready", {31'd0, bus.rep_ready}, {31'd0, m_rep_ready()});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
    check("pend_cnt", {30'd0, bus.pend_cnt}, m_pend);
    check("repe_valid", {31'd0, bus.repe_valid}, {31'd0, m_pend != 0});
    if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q[0]);
  end

  // Observed handshake counts for end-of-test totals.
  int n_out_obs  = 0;
  int n_repe_obs = 0;
  always @(posedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) n_out_obs++;
    if (rstn && bus.repe_valid && bus.repe_ready) n_repe_obs++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(output bit hs);
    @(negedge clk);
    hs = bus.rep_valid && bus.rep_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit hs;
    bus.rep_valid  = 1'b0;
    bus.out_ready  = 1'b1;
    bus.repe_ready = 1'b1;
    bus.replay_en  = 1'b1;
    repeat (6) tick(hs);
  endtask

  initial begin
    bit hs;
    int idx;
    int base_out;
    int base_repe;

    bus.replay_en  = 1'b0;
    bus.rep_valid  = 1'b0;
    bus.rep_data   = '0;
    bus.out_ready  = 1'b0;
    bus.repe_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_pend", {30'd0, bus.pend_cnt}, 32'd0);
    check("rst_rep_ready", {31'd0, bus.rep_ready}, 32'd0);
    rstn = 1'b1;

    // Single packet
    bus.replay_en  = 1'b1;
    bus.out_ready  = 1'b1;
    bus.rep_valid  = 1'b1;
    bus.rep_data   = 32'hA5A5_0001;
    tick(hs);
    check("single_accept", {31'd0, hs}, 32'd1);
    bus.rep_valid = 1'b0;
    check("single_c1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("single_c1_data", bus.out_data, 32'hA5A5_0001);
    tick(hs);
    check("single_c2_pend", {30'd0, bus.pend_cnt}, 32'd1);
    check("single_c2_repe", {31'd0, bus.repe_valid}, 32'd1);
    check("single_c2_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.repe_ready = 1'b1;
    tick(hs);
    check("single_c3_pend", {30'd0, bus.pend_cnt}, 32'd0);
    check("single_c3_repe", {31'd0, bus.repe_valid}, 32'd0);

    // Back-to-back stream
    drain();
    base_out  = n_out_obs;
    base_repe = n_repe_obs;
    for (int i = 0; i < 8; i++) begin
      bus.rep_valid = 1'b1;
      bus.rep_data  = i;
      tick(hs);
      check("b2b_accept", {31'd0, hs}, 32'd1);
      check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
      check("b2b_data", bus.out_data, i);
    end
    bus.rep_valid = 1'b0;
    repeat (3) tick(hs);
    check("b2b_out_count", n_out_obs - base_out, 32'd8);
    check("b2b_repe_count", n_repe_obs - base_repe, 32'd8);
    check("b2b_pend_end", {30'd0, bus.pend_cnt}, 32'd0);

    // CL backpressure
    drain();
    bus.out_ready  = 1'b0;
    bus.repe_ready = 1'b0;
    bus.rep_valid  = 1'b1;
    bus.rep_data   = 32'h11;
    tick(hs);
    check("bp_accept", {31'd0, hs}, 32'd1);
    bus.rep_data = 32'h12;
    base_out = n_out_obs;
    repeat (5) begin
      tick(hs);
      check("bp_no_accept", {31'd0, hs}, 32'd0);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_data", bus.out_data, 32'h11);
      check("bp_hold_pend", {30'd0, bus.pend_cnt}, 32'd0);
    end
    bus.rep_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(hs);
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    tick(hs);
    check("bp_release_pend", {30'd0, bus.pend_cnt}, 32'd1);
    check("bp_once", n_out_obs - base_out, 32'd1);

    // replay_en toggle
    drain();
    bus.out_ready = 1'b0;
    bus.rep_valid = 1'b1;
    bus.rep_data  = 32'h22;
    tick(hs);
    check("en_accept", {31'd0, hs}, 32'd1);
    bus.replay_en = 1'b0;
    bus.rep_data  = 32'h23;
    repeat (2) begin
      tick(hs);
      check("en_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("en_hold_data", bus.out_data, 32'h22);
    end
    bus.out_ready = 1'b1;
    tick(hs);
    check("en_done_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) begin
      tick(hs);
      check("en_blocked", {31'd0, hs}, 32'd0);
    end
    bus.replay_en = 1'b1;
    tick(hs);
    check("en_resume_accept", {31'd0, hs}, 32'd1);
    check("en_resume_data", bus.out_data, 32'h23);
    bus.rep_valid = 1'b0;

    // Counter full (CNT_MAX = 3)
    drain();
    bus.repe_ready = 1'b0;
    bus.rep_valid  = 1'b1;
    idx      = 0;
    base_out = n_out_obs;
    for (int t = 0; t < 8; t++) begin
      bus.rep_data = 32'h30 + idx;
      tick(hs);
      if (hs) idx++;
    end
    check("full_accepted", idx, 32'd3);
    check("full_out_count", n_out_obs - base_out, 32'd3);
    check("full_pend", {30'd0, bus.pend_cnt}, 32'd3);
    check("full_rep_ready", {31'd0, bus.rep_ready}, 32'd0);
    bus.rep_valid  = 1'b0;
    bus.repe_ready = 1'b1;
    tick(hs);
    bus.repe_ready = 1'b0;
    #1;
    check("full_drain_pend", {30'd0, bus.pend_cnt}, 32'd2);
    check("full_reopen", {31'd0, bus.rep_ready}, 32'd1);

    // Asynchronous reset with a held packet and two unreported completions
    drain();
    bus.repe_ready = 1'b0;
    bus.rep_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rep_data = 32'h41 + i;
      tick(hs);
      check("ar_accept", {31'd0, hs}, 32'd1);
    end
    bus.rep_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    check("ar_pre_data", bus.out_data, 32'h43);
    check("ar_pre_pend", {30'd0, bus.pend_cnt}, 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ar_repe_valid", {31'd0, bus.repe_valid}, 32'd0);
    check("ar_pend", {30'd0, bus.pend_cnt}, 32'd0);
    check("ar_rep_ready", {31'd0, bus.rep_ready}, 32'd0);
    check("ar_out_data", bus.out_data, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    bus.rep_valid = 1'b1;
    bus.rep_data  = 32'h55;
    tick(hs);
    check("ar_resume_accept", {31'd0, hs}, 32'd1);
    check("ar_resume_data", bus.out_data, 32'h55);
    bus.rep_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/twowayhandshake_replayer.md
Name: twowayhandshake_replayer

Overview:
- Replay-side counterpart of the record-time two-way-handshake splitter.
- Takes recorded transactions from the replay buffer and re-drives them into the CL on a valid/ready channel.
- Reports each CL-side transaction completion back to the replay controller as an end-of-transaction event, so the controller can order later replay packets against it.
- Sits at the shell boundary in place of the shell interface, one instance per replayed channel.

Parameters:
DATA_WIDTH  32  width of transaction payload
CNT_WIDTH   4   width of the unreported-completion counter; CNT_MAX = 2^CNT_WIDTH-1

Ports:
clk          input   1           clock
rstn         input   1           reset, asynchronous, active-low
replay_en    input   1           controller permission to accept new replay packets
rep_valid    input   1           replay packet valid (transaction start)
rep_ready    output  1           replay packet accepted
rep_data     input   DATA_WIDTH  replay packet payload
out_valid    output  1           valid toward CL
out_ready    input   1           ready from CL
out_data     output  DATA_WIDTH  payload toward CL
repe_valid   output  1           a CL completion is pending report (transaction end)
repe_ready   input   1           controller consumed one completion report
pend_cnt     output  CNT_WIDTH   completions not yet reported

Behaviour:
- Reset is asynchronous and active-low.
  - While rstn=0: out_valid=0, out_data=0, pend_cnt=0, repe_valid=0, rep_ready=0.
  - Reset mid-transaction drops the held packet and all unreported completions.
- Output register FSM, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1, out_data = held payload.
- Transitions:
  - EMPTY -> FULL on rep handshake (rep_valid && rep_ready).
  - FULL -> EMPTY on out handshake (out_valid && out_ready) with no rep handshake in the same cycle.
  - FULL -> FULL with new payload when both handshakes fire in the same cycle (back-to-back, no bubble).
- Latency: rep handshake at cycle N gives out_valid=1 with that data at N+1. Throughput is 1 packet/cycle while the CL holds out_ready=1.
- AXI-stream rules on out:
  - Once out_valid=1, out_valid and out_data stay stable until out_ready=1.
  - Deasserting replay_en never withdraws a presented packet.
  - out_valid never depends combinationally on out_ready.
- rep_ready = rstn && replay_en && (!out_valid || out_ready) && ((pend_cnt + out_valid) < CNT_MAX).
  - The sum is computed in CNT_WIDTH+1 bits.
  - This guarantees the counter can always absorb the completion of every accepted packet, so a completion is never lost and pend_cnt never wraps.
  - rep_ready may depend combinationally on out_ready. It must not depend on rep_valid.
- Completion counter pend_cnt:
  - Increments on an out handshake; decrements on a repe handshake.
  - Both in the same cycle: unchanged.
  - repe_valid = (pend_cnt != 0). Registered only; it does not look ahead at the current out handshake, so a completion is reported at the earliest one cycle after the CL handshake.
  - repe_valid stays asserted until repe_ready, matching the valid-hold rule.
- Ordering invariant: count of rep handshakes = count of out handshakes + out_valid. Count of out handshakes = count of repe handshakes + pend_cnt.
- Boundary: when pend_cnt + out_valid = CNT_MAX, rep_ready=0. Draining one repe re-opens rep_ready the next cycle.
- FORMAL block asserts:
  - the valid-hold rules on out and repe;
  - the invariants above;
  - pend_cnt <= CNT_MAX;
  - out_valid=0 in the cycle after reset.

Test Plan:
- Single packet: replay_en=1, rep 0xA5A5_0001 at cycle 0, out_ready=1 -> out_valid/out_data=0xA5A5_0001 at cycle 1; pend_cnt=1 and repe_valid=1 at cycle 2; repe_ready=1 -> pend_cnt=0 at cycle 3.
- Back-to-back: 8 packets 0..7 streamed, out_ready=1, repe_ready=1 -> out_data 0..7 on consecutive cycles 1..8 with no bubble; 8 repe handshakes; pend_cnt ends 0.
- CL backpressure: out_ready=0 for 5 cycles with packet 0x11 presented -> out_valid and out_data=0x11 held; rep_ready=0; no pend_cnt change; release -> 0x11 transferred once.
- Counter full, CNT_WIDTH=2 (CNT_MAX=3): repe_ready=0, stream packets -> rep_ready drops once pend_cnt + out_valid = 3; exactly 3 packets reach CL; one repe handshake -> rep_ready=1 next cycle.
- replay_en toggle: replay_en drops while packet 0x22 is presented -> 0x22 stays valid and completes; no new packet accepted until replay_en=1.
- Async reset: assert rstn=0 mid-cycle with out_valid=1 and pend_cnt=2 -> out_valid, repe_valid, pend_cnt and rep_ready go to 0 immediately, without waiting for a clock edge; resume cleanly after release.
